// File: rtl/psola_window_multi_buffer.sv
// Multi-channel ping-pong capture buffer plus cleared-on-read overlap-add buffer for the PSOLA engine.
// Optional build macro WINBUF_OVERRUN_COUNT_EN adds a saturating 16-bit discarded-window counter.
module psola_window_multi_buffer #(
    parameter int WIDTH        = 32,
    parameter int CHANNELS     = 1,
    parameter int WINDOW_SIZE  = 2048,
    parameter int MAX_EXTENDED = 2200,
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int WA = $clog2(WINDOW_SIZE),
    localparam int AW = $clog2(MAX_EXTENDED),
    localparam int LW = $clog2(MAX_EXTENDED + 1)
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic [WIDTH*CHANNELS-1:0] in_data,
    input  logic                      in_valid,
    output logic                      proc_start,
    output logic [CW-1:0]             proc_chan,
    input  logic [WA-1:0]             proc_rd_addr,
    output logic [WIDTH-1:0]          proc_rd_data,
    input  logic [AW-1:0]             proc_acc_addr,
    output logic [WIDTH-1:0]          proc_acc_data,
    input  logic                      proc_wr_en,
    input  logic [AW-1:0]             proc_wr_addr,
    input  logic [WIDTH-1:0]          proc_wr_data,
    input  logic                      proc_done,
    input  logic [LW-1:0]             proc_len,
    output logic [WIDTH-1:0]          out_data,
    output logic [CW-1:0]             out_chan,
    output logic                      out_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy,
    output logic                      window_done,
    output logic                      overrun,
    output logic [15:0]               overrun_count
);

    typedef enum logic [2:0] {IDLE, START, PROC, DRAIN, NEXT} state_t;

    localparam logic [LW-1:0] ME_L     = LW'(MAX_EXTENDED);
    localparam logic [AW:0]   ME_A     = (AW + 1)'(MAX_EXTENDED);
    localparam logic [CW-1:0] LAST_CH  = CW'(CHANNELS - 1);
    localparam logic [WA-1:0] LAST_CAP = WA'(WINDOW_SIZE - 1);

    state_t state_q, state_d;

    logic [WIDTH-1:0] sig_mem [CHANNELS][2*WINDOW_SIZE];
    logic [WIDTH-1:0] acc_mem [CHANNELS][MAX_EXTENDED];

    logic [WA-1:0]    cap_addr;
    logic             cap_half, proc_half;
    logic [CW-1:0]    chan;
    logic [LW-1:0]    len_r, drain_addr;
    logic [AW-1:0]    drain_idx;
    logic             boundary, pop, drain_issue;

    logic [WIDTH-1:0] sig_rd_p0, acc_rd_p0, drain_data_p0;
    logic             vld_p0, last_p0;

    logic [WIDTH-1:0] fifo_data [3];
    logic             fifo_last [3];
    logic [1:0]       wr_ptr, rd_ptr, fifo_cnt;

    function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] l);
        return (l > ME_L) ? ME_L : l;
    endfunction

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign boundary  = in_valid && (cap_addr == LAST_CAP);
    assign out_valid = (fifo_cnt != 2'd0);
    assign out_data  = out_valid ? fifo_data[rd_ptr] : '0;
    assign out_last  = out_valid ? fifo_last[rd_ptr] : 1'b0;
    assign out_chan  = chan;
    assign proc_chan = chan;
    assign busy      = (state_q != IDLE);
    assign pop       = out_valid && out_ready;
    assign drain_idx = drain_addr[AW-1:0];
    // Reads in flight count against FIFO space so a stalled sink can never overflow it.
    assign drain_issue = (state_q == DRAIN) && (drain_addr < len_r) &&
                         (({1'b0, fifo_cnt} + {2'b0, vld_p0}) < 3'd3);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state_q <= IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        window_done = 1'b0;
        case (state_q)
            IDLE:  if (boundary) state_d = START;
            START: state_d = PROC;
            PROC:  if (proc_done) state_d = (clamp_len(proc_len) == '0) ? NEXT : DRAIN;
            DRAIN: if (pop && out_last) state_d = NEXT;
            NEXT: begin
                if (chan == LAST_CH) begin
                    window_done = 1'b1;
                    state_d     = IDLE;
                end else begin
                    state_d = START;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cap_addr      <= '0;
            cap_half      <= 1'b0;
            proc_half     <= 1'b0;
            chan          <= '0;
            len_r         <= '0;
            drain_addr    <= '0;
            proc_start    <= 1'b0;
            overrun       <= 1'b0;
            vld_p0        <= 1'b0;
            wr_ptr        <= 2'd0;
            rd_ptr        <= 2'd0;
            fifo_cnt      <= 2'd0;
            proc_rd_data  <= '0;
            proc_acc_data <= '0;
        end else begin
            proc_start <= (state_q == START);
            overrun    <= boundary && (state_q != IDLE);
            if (in_valid) cap_addr <= cap_addr + 1'b1;
            // A window finishing while busy is overwritten in place; the engine keeps its half.
            if (boundary && state_q == IDLE) begin
                cap_half  <= ~cap_half;
                proc_half <= cap_half;
                chan      <= '0;
            end else if (state_q == NEXT && chan != LAST_CH) begin
                chan <= chan + 1'b1;
            end
            if (state_q == PROC && proc_done) begin
                len_r      <= clamp_len(proc_len);
                drain_addr <= '0;
            end else if (drain_issue) begin
                drain_addr <= drain_addr + 1'b1;
            end
            // --- stage p0 -> FIFO
            vld_p0 <= drain_issue;
            if (vld_p0) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)    rd_ptr <= ptr_inc(rd_ptr);
            fifo_cnt <= fifo_cnt + {1'b0, vld_p0} - {1'b0, pop};
            // --- stage p0 -> p1 (engine read ports)
            proc_rd_data  <= sig_rd_p0;
            proc_acc_data <= acc_rd_p0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (in_valid) begin
            for (int c = 0; c < CHANNELS; c++)
                sig_mem[c][{cap_half, cap_addr}] <= in_data[c*WIDTH +: WIDTH];
        end
        // --- stage p0: memory reads
        sig_rd_p0     <= sig_mem[chan][{proc_half, proc_rd_addr}];
        acc_rd_p0     <= ({1'b0, proc_acc_addr} < ME_A) ? acc_mem[chan][proc_acc_addr] : '0;
        drain_data_p0 <= acc_mem[chan][drain_idx];
        last_p0       <= (drain_addr == (len_r - 1'b1));
        if (vld_p0) begin
            fifo_data[wr_ptr] <= drain_data_p0;
            fifo_last[wr_ptr] <= last_p0;
        end
        // Drained locations are zeroed for the next overlap-add pass.
        if (drain_issue)
            acc_mem[chan][drain_idx] <= '0;
        else if (state_q == PROC && proc_wr_en && ({1'b0, proc_wr_addr} < ME_A))
            acc_mem[chan][proc_wr_addr] <= proc_wr_data;
    end

`ifdef WINBUF_OVERRUN_COUNT_EN
    logic [15:0] ovr_cnt;
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            ovr_cnt <= 16'd0;
        else if (boundary && state_q != IDLE && ovr_cnt != 16'hFFFF)
            ovr_cnt <= ovr_cnt + 16'd1;
    end
    assign overrun_count = ovr_cnt;
`else
    assign overrun_count = 16'd0;
`endif

endmodule

// File: tb/tb_psola_window_multi_buffer.sv
// Scoreboard bench for psola_window_multi_buffer: 2 channels, 16-sample windows, 24-sample output buffer.
module tb_psola_window_multi_buffer;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        proc_start;
    logic        proc_chan;
    logic [3:0]  proc_rd_addr = '0;
    logic [15:0] proc_rd_data;
    logic [4:0]  proc_acc_addr = '0;
    logic [15:0] proc_acc_data;
    logic        proc_wr_en = 1'b0;
    logic [4:0]  proc_wr_addr = '0;
    logic [15:0] proc_wr_data = '0;
    logic        proc_done = 1'b0;
    logic [4:0]  proc_len = '0;
    logic [15:0] out_data;
    logic        out_chan;
    logic        out_last;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        busy;
    logic        window_done;
    logic        overrun;
    logic [15:0] overrun_count;

    psola_window_multi_buffer #(
        .WIDTH(16), .CHANNELS(2), .WINDOW_SIZE(16), .MAX_EXTENDED(24)
    ) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .in_data(in_data), .in_valid(in_valid),
        .proc_start(proc_start), .proc_chan(proc_chan),
        .proc_rd_addr(proc_rd_addr), .proc_rd_data(proc_rd_data),
        .proc_acc_addr(proc_acc_addr), .proc_acc_data(proc_acc_data),
        .proc_wr_en(proc_wr_en), .proc_wr_addr(proc_wr_addr), .proc_wr_data(proc_wr_data),
        .proc_done(proc_done), .proc_len(proc_len),
        .out_data(out_data), .out_chan(out_chan), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .window_done(window_done), .overrun(overrun),
        .overrun_count(overrun_count)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [15:0] data;
        logic        chan;
        logic        last;
    } exp_t;

    exp_t        exp_q [$];
    int          checks = 0;
    int          errors = 0;
    int          beat_cnt = 0;
    logic        stall_prev = 1'b0;
    logic [15:0] held_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted beat and checks hold-under-stall.
    always @(negedge clk_in) begin
        exp_t e;
        if (stall_prev && rst_n_in) begin
            chk("stall_valid_held", out_valid, 1);
            chk("stall_data_held", out_data, held_data);
        end
        stall_prev = out_valid && !out_ready;
        held_data  = out_data;
        if (out_valid && out_ready) begin
            beat_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got data %0d chan %0d, expected no beat", out_data, out_chan);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", out_data, e.data);
                chk("out_chan", out_chan, e.chan);
                chk("out_last", out_last, e.last);
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic feed_window(input int b0, input int b1);
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = {16'(b1 + i), 16'(b0 + i)};
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_start(input int ch, input string name);
        for (int n = 0; n < 200; n++) begin
            tick();
            if (proc_start) break;
        end
        chk(name, proc_start, 1);
        chk({name, "_chan"}, proc_chan, ch);
    endtask

    task automatic wait_done(input string name);
        for (int n = 0; n < 200; n++) begin
            tick();
            if (window_done) break;
        end
        chk(name, window_done, 1);
    endtask

    task automatic rd_sig(input int addr, input int exp, input string name);
        proc_rd_addr = 4'(addr);
        tick();
        tick();
        chk(name, proc_rd_data, exp);
    endtask

    task automatic rd_acc(input int addr, input int exp, input string name);
        proc_acc_addr = 5'(addr);
        tick();
        tick();
        chk(name, proc_acc_data, exp);
    endtask

    task automatic write_acc(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            proc_wr_en   = 1'b1;
            proc_wr_addr = 5'(i);
            proc_wr_data = 16'(base + i);
            tick();
        end
        proc_wr_en = 1'b0;
    endtask

    task automatic push_exp(input int n, input int base, input logic ch);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.data = 16'(base + i);
            e.chan = ch;
            e.last = (i == n - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic done(input int len);
        proc_len  = 5'(len);
        proc_done = 1'b1;
        tick();
        proc_done = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_proc_start", proc_start, 0);
        chk("rst_window_done", window_done, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_overrun_count", overrun_count, 0);
        chk("rst_out_data", out_data, 0);
        rst_n_in = 1'b1;
        tick();

        // Window 1: ramp capture, ch0 len 20 with stall, ch1 len 0
        feed_window(0, 200);
        chk("w1_start_early", proc_start, 0);
        chk("w1_busy", busy, 1);
        tick();
        chk("w1_start_pulse", proc_start, 1);
        chk("w1_chan0", proc_chan, 0);
        rd_sig(5, 5, "w1_rd_addr5");
        chk("w1_start_one_cycle", proc_start, 0);
        write_acc(20, 100);
        rd_acc(7, 107, "w1_acc_addr7");
        out_ready = 1'b1;
        beat_cnt  = 0;
        push_exp(20, 100, 1'b0);
        done(20);
        chk("w1_lat_cycle1", out_valid, 0);
        tick();
        chk("w1_lat_cycle2", out_valid, 0);
        tick();
        chk("w1_lat_cycle3", out_valid, 1);
        repeat (5) tick();
        out_ready = 1'b0;
        repeat (10) tick();
        chk("w1_stall_valid", out_valid, 1);
        out_ready = 1'b1;
        wait_start(1, "w1_start_ch1");
        chk("w1_beat_count", beat_cnt, 20);
        chk("w1_queue_empty", exp_q.size(), 0);
        done(0);
        chk("w1_window_done", window_done, 1);
        tick();
        chk("w1_window_done_pulse", window_done, 0);
        chk("w1_idle", busy, 0);

        // Window 2: cleared buffer, ch0 len 0, ch1 len 4
        feed_window(50, 250);
        wait_start(0, "w2_start_ch0");
        rd_acc(3, 0, "w2_acc_cleared");
        rd_sig(2, 52, "w2_rd_half1_ch0");
        beat_cnt = 0;
        done(0);
        wait_start(1, "w2_start_ch1");
        rd_sig(2, 252, "w2_rd_half1_ch1");
        write_acc(4, 300);
        push_exp(4, 300, 1'b1);
        done(4);
        wait_done("w2_window_done");
        chk("w2_beat_count", beat_cnt, 4);
        chk("w2_queue_empty", exp_q.size(), 0);

        // Window 3 in progress while window 4 completes: overrun
        feed_window(70, 270);
        wait_start(0, "w3_start_ch0");
        feed_window(90, 290);
        chk("w4_overrun", overrun, 1);
        chk("w4_busy", busy, 1);
        chk("w4_chan_kept", proc_chan, 0);
`ifdef WINBUF_OVERRUN_COUNT_EN
        chk("w4_overrun_count", overrun_count, 1);
`endif
        tick();
        chk("w4_overrun_pulse", overrun, 0);
        rd_sig(4, 74, "w3_half_untouched");

        // Length clamp: proc_len = MAX_EXTENDED + 5
        write_acc(24, 400);
        push_exp(24, 400, 1'b0);
        beat_cnt = 0;
        done(29);
        wait_start(1, "w3_start_ch1");
        chk("w3_clamp_count", beat_cnt, 24);
        chk("w3_queue_empty", exp_q.size(), 0);
        done(0);
        chk("w3_window_done", window_done, 1);
        tick();

        // Window 5: reset mid-drain
        feed_window(10, 210);
        wait_start(0, "w5_start_ch0");
        write_acc(10, 500);
        push_exp(10, 500, 1'b0);
        beat_cnt = 0;
        done(10);
        for (int n = 0; n < 50; n++) begin
            if (beat_cnt >= 3) break;
            tick();
        end
        chk("w5_some_beats", beat_cnt >= 3, 1);
        rst_n_in = 1'b0;
        #2;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_out_last", out_last, 0);
        chk("arst_busy", busy, 0);
        chk("arst_proc_chan", proc_chan, 0);
        chk("arst_proc_rd_data", proc_rd_data, 0);
        chk("arst_proc_acc_data", proc_acc_data, 0);
        chk("arst_overrun_count", overrun_count, 0);
        exp_q.delete();
        repeat (2) tick();
        rst_n_in = 1'b1;
        repeat (3) tick();
        chk("post_rst_idle", busy, 0);
        chk("post_rst_out_valid", out_valid, 0);
        chk("post_rst_window_done", window_done, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

endmodule
